// File: rtl/divider_ctrl_if.sv
// Configuration request port of divider_ctrl: valid/ready handshake plus a one-cycle reject pulse.
// The master side (requester) drives the payload; the controller drives cfg_ready and cfg_err.
interface divider_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/divider_ctrl.sv
// Two-channel runtime-reconfigurable divider of clock1M; clocks, ticks and cfg_err are registered (1 cycle).
// cfg_ready drops while an accepted update waits for its channel's full-period boundary (<= 2*H_old edges).
module divider_ctrl #(
  parameter int CNT_W         = 8,
  parameter int DEF_FAST_HALF = 5,
  parameter int DEF_SLOW_HALF = 50
) (
  input  logic          clock1M,
  input  logic          reset,
  divider_ctrl_if.slave cfg,
  output logic          clk_100KHz,
  output logic          clk_10KHz,
  output logic          tick_fast,
  output logic          tick_slow,
  output logic [1:0]    ch_en
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] half_q [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] last   [2];
  logic [1:0]       en_q;
  logic [1:0]       out_q;
  logic [1:0]       tick_q;
  logic             sh_ch;
  logic [CNT_W-1:0] sh_half;
  logic             sh_en;
  logic             err_q;
  logic             apply;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      last[i] = half_q[i] - CNT_W'(1);
    end
  end

  // Update lands only where the target channel would finish a full period, or at once if it is stopped.
  always_comb begin
    apply = 1'b0;
    if (state == WAIT) begin
      apply = !en_q[sh_ch] || ((cnt_q[sh_ch] == last[sh_ch]) && out_q[sh_ch]);
    end
  end

  always_ff @(posedge clock1M) begin
    if (reset) begin
      state     <= IDLE;
      half_q[0] <= CNT_W'(DEF_FAST_HALF);
      half_q[1] <= CNT_W'(DEF_SLOW_HALF);
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      en_q      <= 2'b11;
      out_q     <= 2'b00;
      tick_q    <= 2'b00;
      err_q     <= 1'b0;
      sh_ch     <= 1'b0;
      sh_half   <= '0;
      sh_en     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tick_q[i] <= 1'b0;
        if (apply && (sh_ch == 1'(i))) begin
          half_q[i] <= sh_half;
          en_q[i]   <= sh_en;
          cnt_q[i]  <= '0;
          out_q[i]  <= 1'b0;
        end else if (!en_q[i]) begin
          cnt_q[i]  <= '0;
          out_q[i]  <= 1'b0;
        end else if (cnt_q[i] == last[i]) begin
          cnt_q[i]  <= '0;
          out_q[i]  <= !out_q[i];
          tick_q[i] <= !out_q[i];
        end else begin
          cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            if (cfg.cfg_half == '0) begin
              err_q <= 1'b1;
            end else begin
              sh_ch   <= cfg.cfg_ch;
              sh_half <= cfg.cfg_half;
              sh_en   <= cfg.cfg_en;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (apply) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = (state == IDLE);
  assign cfg.cfg_err   = err_q;
  assign clk_100KHz    = out_q[0];
  assign clk_10KHz     = out_q[1];
  assign tick_fast     = tick_q[0];
  assign tick_slow     = tick_q[1];
  assign ch_en         = en_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Scoreboard bench for divider_ctrl: expected waveforms come from closed-form period/phase formulas,
// queued against absolute cycle numbers and compared on the falling edge after each rising edge.
module tb_divider_ctrl;
  localparam int CNT_W = 8;

  logic       clock1M = 1'b0;
  logic       reset   = 1'b1;
  logic       clk_100KHz;
  logic       clk_10KHz;
  logic       tick_fast;
  logic       tick_slow;
  logic [1:0] ch_en;

  divider_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  divider_ctrl #(
    .CNT_W         (CNT_W),
    .DEF_FAST_HALF (5),
    .DEF_SLOW_HALF (50)
  ) dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .cfg        (cfg_if),
    .clk_100KHz (clk_100KHz),
    .clk_10KHz  (clk_10KHz),
    .tick_fast  (tick_fast),
    .tick_slow  (tick_slow),
    .ch_en      (ch_en)
  );

  typedef struct {
    int         at;
    int         sig;
    logic [1:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   base   = 0;

  always #5 clock1M = ~clock1M;
  always @(posedge clock1M) cyc++;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, exp, cyc - base);
    end
  endtask

  // sig ids: 0 clk_100KHz, 1 clk_10KHz, 2 tick_fast, 3 tick_slow, 4 ch_en, 5 cfg_ready, 6 cfg_err
  function automatic logic [1:0] obs(input int sig);
    case (sig)
      0:       return {1'b0, clk_100KHz};
      1:       return {1'b0, clk_10KHz};
      2:       return {1'b0, tick_fast};
      3:       return {1'b0, tick_slow};
      4:       return ch_en;
      5:       return {1'b0, cfg_if.cfg_ready};
      6:       return {1'b0, cfg_if.cfg_err};
      default: return 2'bxx;
    endcase
  endfunction

  always @(negedge clock1M) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == cyc) begin
        check_eq(sb[k].tag, 32'(obs(sb[k].sig)), 32'(sb[k].val));
        sb.delete(k);
      end
    end
  end

  task automatic push(input int e, input int sig, input logic [1:0] v, input string tag);
    exp_t x;
    x.at  = base + e;
    x.sig = sig;
    x.val = v;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Channel restarted (counter 0, output 0) at edge s with half-period h: rises at s+h, falls at s+2h.
  task automatic exp_clk(input int ch, input int s, input int h, input int from, input int to);
    for (int e = from; e <= to; e++) begin
      push(e, ch, 2'(((e - s) / h) % 2), (ch != 0) ? "clk_10KHz" : "clk_100KHz");
      push(e, ch + 2, (((e - s) % (2 * h)) == h) ? 2'd1 : 2'd0, (ch != 0) ? "tick_slow" : "tick_fast");
    end
  endtask

  task automatic exp_flat(input int sig, input int from, input int to, input logic [1:0] v, input string tag);
    for (int e = from; e <= to; e++) begin
      push(e, sig, v, tag);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < base + e) begin
      @(posedge clock1M);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic ch, input logic [CNT_W-1:0] h, input logic en);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_half  = h;
    cfg_if.cfg_en    = en;
  endtask

  task automatic send(input int e, input logic ch, input logic [CNT_W-1:0] h, input logic en);
    wait_edge(e - 1);
    drive(1'b1, ch, h, en);
    wait_edge(e);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock1M);
    #1;
    check_eq("reset_state",
             {24'd0, clk_100KHz, clk_10KHz, tick_fast, tick_slow, ch_en, cfg_if.cfg_ready, cfg_if.cfg_err},
             32'b0000_11_1_0);
    reset = 1'b0;
    base  = cyc;
  endtask

  initial begin
    int acc;
    drive(1'b0, 1'b0, '0, 1'b0);
    do_reset(3);

    exp_clk(0, 0, 5, 1, 10);
    exp_clk(0, 10, 2, 11, 150);
    exp_clk(0, 150, 3, 151, 162);
    exp_clk(1, 0, 50, 1, 100);
    exp_flat(1, 101, 121, 2'd0, "clk_10KHz_off");
    exp_flat(3, 101, 121, 2'd0, "tick_slow_off");
    exp_clk(1, 121, 3, 122, 145);
    exp_clk(1, 145, 4, 146, 162);
    exp_flat(4, 1, 99, 2'b11, "ch_en");
    exp_flat(4, 100, 120, 2'b01, "ch_en_slow_off");
    exp_flat(4, 121, 162, 2'b11, "ch_en");
    exp_flat(5, 1, 6, 2'd1, "ready");
    exp_flat(5, 7, 9, 2'd0, "ready_wait_fast");
    exp_flat(5, 10, 59, 2'd1, "ready");
    exp_flat(5, 60, 99, 2'd0, "ready_wait_slow");
    exp_flat(5, 100, 119, 2'd1, "ready");
    exp_flat(5, 120, 120, 2'd0, "ready_wait_off");
    exp_flat(5, 121, 139, 2'd1, "ready_err");
    exp_flat(5, 140, 144, 2'd0, "ready_b2b_1");
    exp_flat(5, 145, 145, 2'd1, "ready_gap");
    exp_flat(5, 146, 149, 2'd0, "ready_b2b_2");
    exp_flat(5, 150, 161, 2'd1, "ready_once");
    exp_flat(5, 162, 162, 2'd0, "ready_wait_rst");
    exp_flat(6, 1, 129, 2'd0, "err_idle");
    push(130, 6, 2'd1, "err_pulse");
    exp_flat(6, 131, 162, 2'd0, "err_idle");

    send(7, 1'b0, 8'd2, 1'b1);
    send(60, 1'b1, 8'd50, 1'b0);
    send(120, 1'b1, 8'd3, 1'b1);
    send(130, 1'b1, 8'd0, 1'b1);

    // Slow update accepted at 140; a fast update is then held on the port until cfg_ready returns.
    wait_edge(139);
    drive(1'b1, 1'b1, 8'd4, 1'b1);
    wait_edge(140);
    drive(1'b1, 1'b0, 8'd3, 1'b1);
    acc = -1;
    for (int n = 0; n < 20 && acc < 0; n++) begin
      @(negedge clock1M);
      if (cfg_if.cfg_ready) begin
        @(posedge clock1M);
        #1;
        acc = cyc - base;
        cfg_if.cfg_valid = 1'b0;
      end
    end
    cfg_if.cfg_valid = 1'b0;
    check_eq("b2b_accept_edge", acc, 146);

    send(162, 1'b1, 8'd7, 1'b0);
    do_reset(2);

    exp_clk(0, 0, 5, 1, 60);
    exp_clk(1, 0, 50, 1, 110);
    exp_flat(4, 1, 110, 2'b11, "ch_en_after_rst");
    exp_flat(5, 1, 110, 2'd1, "ready_after_rst");
    exp_flat(6, 1, 110, 2'd0, "err_after_rst");
    wait_edge(111);
    check_eq("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
